// File: rtl/block_deserializer.sv
// rtl/block_deserializer.sv - packs N consecutive BSIZE-bit stream words into one BLOCK-bit block
// The first accepted word lands in the top bits; output is registered with a one-gate ready path.
module block_deserializer #(
  parameter int BSIZE = 32,
  parameter int BLOCK = 128
) (
  input  logic             clk,
  input  logic             syn_rst,
  input  logic [BSIZE-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BLOCK-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int N  = BLOCK / BSIZE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((BLOCK % BSIZE) != 0 || N < 2) begin : g_bad_params
      $error("block_deserializer: BLOCK must be a multiple of BSIZE with at least two words");
    end
  endgenerate

  logic [BLOCK-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             in_fire;
  logic             last_word;

  // Accepting in the same cycle the pending block drains keeps throughput at one block per N cycles.
  assign in_ready  = !syn_rst & (!full | out_ready);
  assign in_fire   = in_valid & in_ready;
  assign last_word = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      sreg <= '0;
      cnt  <= '0;
      full <= 1'b0;
    end else begin
      if (in_fire) begin
        sreg <= {sreg[BLOCK-BSIZE-1:0], in_data};
        cnt  <= last_word ? '0 : cnt + CW'(1);
      end
      // With N >= 2 a completing word can never coincide with the pending block draining.
      full <= (full & !out_ready) | (in_fire & last_word);
    end
  end

  assign out_data  = sreg;
  assign out_valid = full;

endmodule

// File: tb/tb_block_deserializer.sv
// tb/tb_block_deserializer.sv - scoreboard bench for block_deserializer
// Stimulus pushes hand-computed blocks; a negedge monitor pops and compares on every output transfer.
module tb_block_deserializer;

  logic         clk = 1'b0;
  logic         syn_rst;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [127:0] exp_q[$];
  int           fire_q[$];

  block_deserializer #(.BSIZE(32), .BLOCK(128)) dut (
    .clk(clk), .syn_rst(syn_rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor plus hold-stability check under backpressure.
  logic         prev_hold = 1'b0;
  logic [127:0] prev_data = '0;
  always @(negedge clk) begin
    if (prev_hold && !syn_rst) begin
      check("hold_valid", {127'd0, out_valid}, 128'd1);
      check("hold_data", out_data, prev_data);
    end
    prev_hold = out_valid & !out_ready & !syn_rst;
    prev_data = out_data;
    if (!syn_rst && out_valid && out_ready) begin
      fire_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block: got %h expected none", out_data);
      end else begin
        check("block", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic push_word(input logic [31:0] w, output int stalls, output int acc_cyc);
    bit acc = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    stalls   = 0;
    acc_cyc  = 0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) acc_cyc = cyc;
      else stalls++;
      @(posedge clk); #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: word %h not accepted, expected acceptance", w);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    int st, ac, tot_st, first_cyc, idx, wc;
    bit acc;
    logic [127:0] mblk;
    logic [31:0] w;

    syn_rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    @(negedge clk);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd0);
    check("rst_out_data", out_data, 128'd0);
    step();
    syn_rst = 1'b0;

    // Basic block with consumer ready.
    out_ready = 1'b1;
    exp_q.push_back(128'h00112233_44556677_8899AABB_CCDDEEFF);
    tot_st = 0;
    push_word(32'h00112233, st, ac); tot_st += st;
    push_word(32'h44556677, st, ac); tot_st += st;
    push_word(32'h8899AABB, st, ac); tot_st += st;
    push_word(32'hCCDDEEFF, st, ac); tot_st += st;
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_valid_after_4th", {127'd0, out_valid}, 128'd1);
    check("t1_no_stall", 128'(tot_st), 128'd0);
    step();

    // Backpressure for 5 cycles, next word accepted only when drained.
    out_ready = 1'b0;
    exp_q.push_back(128'h00112233_44556677_8899AABB_CCDDEEFF);
    push_word(32'h00112233, st, ac);
    push_word(32'h44556677, st, ac);
    push_word(32'h8899AABB, st, ac);
    push_word(32'hCCDDEEFF, st, ac);
    in_data = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_in_ready_full", {127'd0, in_ready}, 128'd0);
      check("t2_held_data", out_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
      step();
    end
    out_ready = 1'b1;
    exp_q.push_back(128'h11111111_22222222_33333333_44444444);
    push_word(32'h11111111, st, ac);
    check("t2_5th_immediate", 128'(st), 128'd0);
    push_word(32'h22222222, st, ac);
    push_word(32'h33333333, st, ac);
    push_word(32'h44444444, st, ac);
    in_valid = 1'b0;
    repeat (3) step();

    // Continuous stream of 1..12; blocks every 4 cycles.
    fire_q.delete();
    exp_q.push_back({32'd1, 32'd2, 32'd3, 32'd4});
    exp_q.push_back({32'd5, 32'd6, 32'd7, 32'd8});
    exp_q.push_back({32'd9, 32'd10, 32'd11, 32'd12});
    tot_st = 0;
    first_cyc = 0;
    for (int i = 1; i <= 12; i++) begin
      push_word(32'(i), st, ac);
      tot_st += st;
      if (i == 1) first_cyc = ac;
    end
    in_valid = 1'b0;
    repeat (3) step();
    check("t3_no_stall", 128'(tot_st), 128'd0);
    check("t3_fire_count", 128'(fire_q.size()), 128'd3);
    for (int k = 0; k < 3 && k < fire_q.size(); k++)
      check("t3_fire_cycle", 128'(fire_q[k] - first_cyc), 128'(4 * (k + 1)));

    // Reset mid-block discards collected words.
    push_word(32'h000000E1, st, ac);
    push_word(32'h000000E2, st, ac);
    in_valid = 1'b0;
    syn_rst = 1'b1;
    step();
    @(negedge clk);
    check("t5_rst_in_ready", {127'd0, in_ready}, 128'd0);
    check("t5_rst_out_data", out_data, 128'd0);
    step();
    syn_rst = 1'b0;
    exp_q.push_back({32'hA, 32'hB, 32'hC, 32'hD});
    push_word(32'hA, st, ac);
    push_word(32'hB, st, ac);
    push_word(32'hC, st, ac);
    push_word(32'hD, st, ac);
    in_valid = 1'b0;
    repeat (2) step();

    // Reset with a block pending; it must never be delivered.
    out_ready = 1'b0;
    push_word(32'hDEAD0001, st, ac);
    push_word(32'hDEAD0002, st, ac);
    push_word(32'hDEAD0003, st, ac);
    push_word(32'hDEAD0004, st, ac);
    in_valid = 1'b0;
    @(negedge clk);
    check("t6_pending", {127'd0, out_valid}, 128'd1);
    step();
    syn_rst = 1'b1;
    step();
    @(negedge clk);
    check("t6_rst_valid", {127'd0, out_valid}, 128'd0);
    check("t6_rst_in_ready", {127'd0, in_ready}, 128'd0);
    step();
    syn_rst = 1'b0;
    @(negedge clk);
    check("t6_post_in_ready", {127'd0, in_ready}, 128'd1);
    step();
    out_ready = 1'b1;
    repeat (4) step();

    // Random valid/ready, 1000 words against a software packer.
    idx = 0; wc = 0; mblk = '0;
    for (int c = 0; c < 20000 && idx < 1000; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        in_data  = $urandom;
      end
      @(negedge clk);
      acc = in_valid & in_ready;
      w = in_data;
      step();
      if (acc) begin
        mblk = {mblk[95:0], w};
        wc++;
        if (wc == 4) begin
          exp_q.push_back(mblk);
          wc = 0;
        end
        idx++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("rand_word_count", 128'(idx), 128'd1000);
    out_ready = 1'b1;
    repeat (4) step();
    check("final_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
